// File: rtl/encode_imm_inst.sv
// OP-IMM instruction encoder: turns an ALU control code plus register/immediate fields into a
// RV32I I-type word, buffered through a 2-entry in-order result FIFO with transfer counters.

`ifndef ADDI
`define ADDI 5'd0
`endif
`ifndef SLLI
`define SLLI 5'd1
`endif
`ifndef SLTI
`define SLTI 5'd2
`endif
`ifndef SLTIU
`define SLTIU 5'd3
`endif
`ifndef XORI
`define XORI 5'd4
`endif
`ifndef SRLI
`define SRLI 5'd5
`endif
`ifndef SRAI
`define SRAI 5'd6
`endif
`ifndef ORI
`define ORI 5'd7
`endif
`ifndef ANDI
`define ANDI 5'd8
`endif

module encode_imm_inst (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_control,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rd,
  input  logic [11:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [6:0]  OpImm = 7'b0010011;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  // Encoder
  logic [2:0]  funct3;
  logic [11:0] imm_field;
  logic        enc_err;
  logic [31:0] enc_instr;

  always_comb begin
    funct3    = 3'd0;
    imm_field = imm;
    enc_err   = 1'b0;
    case (alu_control)
      `ADDI:  funct3 = 3'd0;
      `SLTI:  funct3 = 3'd2;
      `SLTIU: funct3 = 3'd3;
      `XORI:  funct3 = 3'd4;
      `ORI:   funct3 = 3'd6;
      `ANDI:  funct3 = 3'd7;
      `SLLI: begin
        funct3    = 3'd1;
        imm_field = {7'h00, imm[4:0]};
        enc_err   = |imm[11:5];
      end
      `SRLI: begin
        funct3    = 3'd5;
        imm_field = {7'h00, imm[4:0]};
        enc_err   = |imm[11:5];
      end
      `SRAI: begin
        funct3    = 3'd5;
        imm_field = {7'h20, imm[4:0]};
        enc_err   = |imm[11:5];
      end
      default: enc_err = 1'b1;
    endcase
    enc_instr = enc_err ? Nop : {imm_field, rs1, funct3, rd, OpImm};
  end

  // Result FIFO: head is the output register itself, so it holds its last value when empty.
  logic [1:0]  count_q, count_d;
  logic        in_ready_q;
  logic [31:0] head_instr_q, head_instr_d;
  logic        head_err_q, head_err_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic        tail_err_q, tail_err_d;
  logic [15:0] enc_count_q, enc_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  always_comb begin
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_err_d   = head_err_q;
    tail_instr_d = tail_instr_q;
    tail_err_d   = tail_err_q;
    case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
        end else begin
          tail_instr_d = enc_instr;
          tail_err_d   = enc_err;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          head_instr_d = tail_instr_q;
          head_err_d   = tail_err_q;
        end
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
        end else begin
          head_instr_d = tail_instr_q;
          head_err_d   = tail_err_q;
          tail_instr_d = enc_instr;
          tail_err_d   = enc_err;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (pop) begin
      enc_count_d = enc_count_q + 16'd1;
      if (head_err_q && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      in_ready_q   <= 1'b0;
      head_instr_q <= 32'h0;
      head_err_q   <= 1'b0;
      tail_instr_q <= 32'h0;
      tail_err_q   <= 1'b0;
      enc_count_q  <= 16'h0;
      err_count_q  <= 8'h0;
    end else begin
      count_q      <= count_d;
      in_ready_q   <= (count_d < 2'd2);
      head_instr_q <= head_instr_d;
      head_err_q   <= head_err_d;
      tail_instr_q <= tail_instr_d;
      tail_err_q   <= tail_err_d;
      enc_count_q  <= enc_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign instr     = head_instr_q;
  assign out_err   = head_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_encode_imm_inst.sv
// Scoreboard bench for encode_imm_inst: expected results queued at input transfer, compared
// against the FIFO head every cycle and retired at output transfer.

`ifndef ADDI
`define ADDI 5'd0
`endif
`ifndef SLLI
`define SLLI 5'd1
`endif
`ifndef SLTI
`define SLTI 5'd2
`endif
`ifndef SLTIU
`define SLTIU 5'd3
`endif
`ifndef XORI
`define XORI 5'd4
`endif
`ifndef SRLI
`define SRLI 5'd5
`endif
`ifndef SRAI
`define SRAI 5'd6
`endif
`ifndef ORI
`define ORI 5'd7
`endif
`ifndef ANDI
`define ANDI 5'd8
`endif

module tb_encode_imm_inst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_control = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rd = '0;
  logic [11:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  encode_imm_inst dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .rs1         (rs1),
    .rd          (rd),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr       (instr),
    .out_err     (out_err),
    .enc_count   (enc_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } res_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  res_t        sb[$];
  res_t        exp_in;
  res_t        last_res;
  logic [15:0] m_enc;
  logic [7:0]  m_err;
  logic        mon_en = 1'b0;
  logic        rdy_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [4:0] ctl, input logic [4:0] a,
                                 input logic [4:0] d, input logic [11:0] im);
    logic [2:0]  f;
    logic [11:0] fld;
    logic        bad;
    res_t        r;
    f   = 3'd0;
    fld = im;
    bad = 1'b0;
    case (ctl)
      `ADDI:  f = 3'd0;
      `SLTI:  f = 3'd2;
      `SLTIU: f = 3'd3;
      `XORI:  f = 3'd4;
      `ORI:   f = 3'd6;
      `ANDI:  f = 3'd7;
      `SLLI:  begin f = 3'd1; bad = (im[11:5] != 7'h0); fld = {7'h00, im[4:0]}; end
      `SRLI:  begin f = 3'd5; bad = (im[11:5] != 7'h0); fld = {7'h00, im[4:0]}; end
      `SRAI:  begin f = 3'd5; bad = (im[11:5] != 7'h0); fld = {7'h20, im[4:0]}; end
      default: bad = 1'b1;
    endcase
    r.err   = bad;
    r.instr = bad ? 32'h0000_0013 : {fld, a, f, d, 7'b0010011};
    return r;
  endfunction

  // Per-cycle scoreboard: head, valid, ready and counters against the model.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("out_valid", out_valid, sb.size() != 0);
      check("enc_count", enc_count, m_enc);
      check("err_count", err_count, m_err);
      if (rdy_chk) check("in_ready", in_ready, sb.size() < 2);
      if (sb.size() != 0) begin
        check("instr", instr, sb[0].instr);
        check("out_err", out_err, sb[0].err);
        if (out_ready) begin
          last_res = sb.pop_front();
          m_enc++;
          if (last_res.err && m_err != 8'hFF) m_err++;
        end
      end else begin
        check("hold_instr", instr, last_res.instr);
        check("hold_err", out_err, last_res.err);
      end
      if (in_valid && in_ready) sb.push_back(exp_in);
    end
  end

  task automatic apply_reset();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    rdy_chk = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_instr", instr, 0);
    check("rst_out_err", out_err, 0);
    check("rst_enc_count", enc_count, 0);
    check("rst_err_count", err_count, 0);
    sb.delete();
    m_enc = '0;
    m_err = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rdy_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    mon_en  = 1'b1;
    rdy_chk = 1'b1;
  endtask

  task automatic send(input logic [4:0] ctl, input logic [4:0] a, input logic [4:0] d,
                      input logic [11:0] im, input res_t e);
    alu_control = ctl;
    rs1 = a;
    rd  = d;
    imm = im;
    exp_in = e;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [4:0] ctl, input logic [4:0] a, input logic [4:0] d,
                        input logic [11:0] im);
    send(ctl, a, d, im, model(ctl, a, d, im));
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) return;
    end
    check("drain_timeout", out_valid, 0);
  endtask

  initial begin
    logic  done;
    res_t  e;
    #3 apply_reset();

    // Directed encodings
    out_ready = 1'b1;
    e = '{err: 1'b0, instr: 32'h0051_0093};
    send(`ADDI, 5'd2, 5'd1, 12'd5, e);
    wait_empty();
    check("addi_enc_count", enc_count, 16'd1);
    e = '{err: 1'b0, instr: 32'h4022_5193};
    send(`SRAI, 5'd4, 5'd3, 12'd2, e);
    e = '{err: 1'b0, instr: 32'h0022_5193};
    send(`SRLI, 5'd4, 5'd3, 12'd2, e);
    e = '{err: 1'b1, instr: 32'h0000_0013};
    send(`SLLI, 5'd4, 5'd3, 12'h021, e);
    wait_empty();
    check("slli_err_count", err_count, 8'd1);
    send_m(`SLTIU, 5'd31, 5'd30, 12'hFFF);
    send_m(`XORI, 5'd7, 5'd9, 12'h800);
    send_m(`ANDI, 5'd1, 5'd0, 12'h0F0);
    send_m(5'd31, 5'd5, 5'd6, 12'h001);
    send_m(`SRAI, 5'd5, 5'd6, 12'h41F);
    wait_empty();

    // Backpressure: two accepted, third held until the consumer drains
    out_ready = 1'b0;
    send_m(`ORI, 5'd1, 5'd2, 12'h111);
    send_m(`SLTI, 5'd3, 5'd4, 12'h222);
    check("full_in_ready", in_ready, 0);
    done = 1'b0;
    fork
      send_m(`SLLI, 5'd5, 5'd6, 12'h01F);
      begin
        repeat (3) @(posedge clk);
        #1 check("third_held", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Reset with two entries buffered and non-zero counters
    out_ready = 1'b0;
    send_m(`ADDI, 5'd8, 5'd9, 12'h00A);
    send_m(`SLLI, 5'd8, 5'd9, 12'hFFF);
    @(posedge clk);
    #2 apply_reset();

    // Counter wrap and saturation
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) send_m(`ADDI, 5'(i), 5'(i >> 5), 12'(i));
    wait_empty();
    check("enc_wrap", enc_count, 16'd1);
    for (int i = 0; i < 300; i++) send_m(`SLLI, 5'd1, 5'd2, 12'hFE0);
    wait_empty();
    check("err_sat", err_count, 8'hFF);
    check("enc_after_sat", enc_count, 16'd301);

    // Random traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          logic [4:0]  c, a, d;
          logic [11:0] im;
          c  = 5'($urandom_range(0, 11));
          a  = 5'($urandom);
          d  = 5'($urandom);
          im = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 31)) : 12'($urandom);
          send_m(c, a, d, im);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encode_imm_inst.md
ENCODE_IMM_INST -- requirements
Module: encode_imm_inst

Interface
REQ-001 Parameter: none; ALU control codes SHALL be the codebase's shared defines ADDI, SLLI, SLTI, SLTIU, XORI, SRLI, SRAI, ORI, ANDI.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request carries a field set to encode.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 alu_control  input  5  operation code (shared defines).
REQ-007 rs1  input  5  source register index.
REQ-008 rd  input  5  destination register index.
REQ-009 imm  input  12  immediate; for shifts, imm[4:0] is shamt.
REQ-010 out_valid  output  1  instr/out_err hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 instr  output  32  encoded OP-IMM instruction word.
REQ-013 out_err  output  1  result is an illegal request; instr is 32'h0000_0013 (NOP).
REQ-014 enc_count  output  16  number of results accepted by consumer, wraps.
REQ-015 err_count  output  8  number of illegal results accepted by consumer, saturates at 255.

Function
REQ-016 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer on out_valid=1 and out_ready=1.
REQ-017 Results SHALL be held in a 2-entry in-order FIFO; in_ready SHALL equal (occupancy < 2), registered, with no combinational path from out_ready.
REQ-018 A request accepted at edge N SHALL appear at the FIFO head no earlier than after edge N (out_valid high in cycle N+1 if FIFO was empty).
REQ-019 Encoding: instr[6:0]=7'b0010011, [11:7]=rd, [14:12]=funct3, [19:15]=rs1, [31:20]=immediate field.
REQ-020 funct3: ADDI 0, SLLI 1, SLTI 2, SLTIU 3, XORI 4, SRLI 5, SRAI 5, ORI 6, ANDI 7.
REQ-021 ADDI/SLTI/SLTIU/XORI/ORI/ANDI: [31:20]=imm unchanged.
REQ-022 SLLI/SRLI: [31:20]={7'h00, imm[4:0]}; SRAI: [31:20]={7'h20, imm[4:0]}.
REQ-023 Shift requests with imm[11:5] != 0, or any alu_control not listed in REQ-020, SHALL be illegal: out_err=1, instr=32'h0000_0013.
REQ-024 Head entry SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order; pop at occupancy 1 with push SHALL present the new entry next cycle.
REQ-026 enc_count SHALL increment by 1 per output transfer, 16'hFFFF -> 16'h0000.
REQ-027 err_count SHALL increment per output transfer with out_err=1, holding at 8'hFF.
REQ-028 out_valid=0 SHALL leave instr/out_err at last value (no X requirement on consumer).

Reset
REQ-029 rst_n=0 SHALL immediately clear FIFO occupancy, out_valid=0, in_ready=0 while asserted, instr=0, out_err=0, enc_count=0, err_count=0.
REQ-030 in_ready SHALL rise on the first clock edge after rst_n deasserts; reset mid-transfer SHALL discard all buffered results.

Verification
REQ-031 ADDI, rd=1, rs1=2, imm=5, out_ready=1 -> next cycle out_valid=1, instr=0x00510093, out_err=0; enc_count=1 after transfer.
REQ-032 SRAI, rd=3, rs1=4, imm=2 -> instr=0x40225193; SRLI same fields -> 0x00225193.
REQ-033 SLLI with imm=12'h021 -> out_err=1, instr=0x00000013, err_count=1 after transfer.
REQ-034 out_ready=0, three back-to-back requests -> in_ready low after two accepts, third held; release out_ready -> three results in order, no loss or duplication.
REQ-035 65537 legal transfers -> enc_count=1; 300 illegal transfers -> err_count=255.
REQ-036 rst_n low with 2 entries buffered -> out_valid=0 and counters 0 immediately, without clock.
